// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared single-access-per-cycle memory/IO bus.
// Round-robin priority with a bounded burst; read data routed back one cycle after the grant.
module mem_bus_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  owner_t     owner;
  logic       last;
  logic [3:0] burst_cnt;
  logic       rd_pend;
  logic       rd_port;
  logic       same_owner;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= BURST_MAX) ? BURST_MAX : cnt + 4'd1;
  endfunction

  // Grant decision: combinational from the requests and the previous cycle's owner.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && !req1) begin
        gnt0 = 1'b1;
      end else if (!req0 && req1) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        unique case (owner)
          OWN_P0: begin
            if (burst_cnt < BURST_MAX) gnt0 = 1'b1;
            else                       gnt1 = 1'b1;
          end
          OWN_P1: begin
            if (burst_cnt < BURST_MAX) gnt1 = 1'b1;
            else                       gnt0 = 1'b1;
          end
          default: begin
            if (last) gnt0 = 1'b1;
            else      gnt1 = 1'b1;
          end
        endcase
      end
    end
  end

  assign busy       = gnt0 | gnt1;
  assign same_owner = (gnt0 && owner == OWN_P0) || (gnt1 && owner == OWN_P1);

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    if (gnt0) begin
      bus_addr  = addr0;
      bus_wdata = wdata0;
      bus_we    = we0;
    end else if (gnt1) begin
      bus_addr  = addr1;
      bus_wdata = wdata1;
      bus_we    = we1;
    end
  end

  // Arbitration state and read-pending flag, registered at the end of the grant cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_NONE;
      last      <= 1'b1;
      burst_cnt <= 4'd0;
      rd_pend   <= 1'b0;
    end else if (busy) begin
      owner     <= gnt0 ? OWN_P0 : OWN_P1;
      last      <= gnt1;
      burst_cnt <= same_owner ? sat_inc(burst_cnt) : 4'd1;
      rd_pend   <= !bus_we;
    end else begin
      owner     <= OWN_NONE;
      burst_cnt <= 4'd0;
      rd_pend   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (busy) rd_port <= gnt1;
  end

  // Read return stage: bus data belongs to whichever port was granted a read last cycle.
  assign rvalid0 = rd_pend && !rd_port && !reset;
  assign rvalid1 = rd_pend &&  rd_port && !reset;
  assign rdata0  = rvalid0 ? bus_rdata : '0;
  assign rdata1  = rvalid1 ? bus_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (burst limits 4 and 1) on shared stimulus,
// checked every cycle against a behavioural model plus hand-computed literal expectations.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1, bus_rdata;

  logic [1:0]  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, bus_we_o, busy_o;
  logic [7:0]  rdata0_o [2];
  logic [7:0]  rdata1_o [2];
  logic [7:0]  bus_wdata_o [2];
  logic [15:0] bus_addr_o [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_BURST(4), .ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
    .gnt0(gnt0_o[0]), .rdata0(rdata0_o[0]), .rvalid0(rvalid0_o[0]),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
    .gnt1(gnt1_o[0]), .rdata1(rdata1_o[0]), .rvalid1(rvalid1_o[0]),
    .bus_addr(bus_addr_o[0]), .bus_wdata(bus_wdata_o[0]), .bus_we(bus_we_o[0]),
    .bus_rdata(bus_rdata), .busy(busy_o[0])
  );

  mem_bus_arbiter #(.MAX_BURST(1), .ADDR_W(16), .DATA_W(8)) dut1 (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
    .gnt0(gnt0_o[1]), .rdata0(rdata0_o[1]), .rvalid0(rvalid0_o[1]),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
    .gnt1(gnt1_o[1]), .rdata1(rdata1_o[1]), .rvalid1(rvalid1_o[1]),
    .bus_addr(bus_addr_o[1]), .bus_wdata(bus_wdata_o[1]), .bus_we(bus_we_o[1]),
    .bus_rdata(bus_rdata), .busy(busy_o[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s [inst %0d] at %0t: got %0h, expected %0h", nm, k, $time, act, exp_v);
    end
  endtask

  // Behavioural model: owner (-1 none), last port granted, length of the current
  // uninterrupted run, and the port whose read returns this cycle (-1 none).
  int mb [2] = '{4, 1};
  int m_owner [2] = '{-1, -1};
  int m_last  [2] = '{1, 1};
  int m_run   [2] = '{0, 0};
  int m_pend  [2] = '{-1, -1};
  int          g;
  logic [15:0] ea;
  logic [7:0]  ed;
  logic        ew;
  logic        rv0, rv1;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      g = -1;
      if (!reset) begin
        if (req0 && !req1)      g = 0;
        else if (req1 && !req0) g = 1;
        else if (req0 && req1) begin
          if (m_owner[k] < 0)             g = 1 - m_last[k];
          else if (m_run[k] < mb[k])      g = m_owner[k];
          else                            g = 1 - m_owner[k];
        end
      end
      ea = 16'h0; ed = 8'h0; ew = 1'b0;
      if (g == 0) begin ea = addr0; ed = wdata0; ew = we0; end
      if (g == 1) begin ea = addr1; ed = wdata1; ew = we1; end
      rv0 = !reset && m_pend[k] == 0;
      rv1 = !reset && m_pend[k] == 1;

      chk("gnt0",      k, gnt0_o[k],      g == 0);
      chk("gnt1",      k, gnt1_o[k],      g == 1);
      chk("busy",      k, busy_o[k],      g >= 0);
      chk("bus_addr",  k, bus_addr_o[k],  ea);
      chk("bus_wdata", k, bus_wdata_o[k], ed);
      chk("bus_we",    k, bus_we_o[k],    ew);
      chk("rvalid0",   k, rvalid0_o[k],   rv0);
      chk("rvalid1",   k, rvalid1_o[k],   rv1);
      chk("rdata0",    k, rdata0_o[k],    rv0 ? bus_rdata : 8'h0);
      chk("rdata1",    k, rdata1_o[k],    rv1 ? bus_rdata : 8'h0);

      if (reset) begin
        m_owner[k] = -1; m_last[k] = 1; m_run[k] = 0; m_pend[k] = -1;
      end else if (g < 0) begin
        m_owner[k] = -1; m_run[k] = 0; m_pend[k] = -1;
      end else begin
        m_run[k]   = (g == m_owner[k]) ? m_run[k] + 1 : 1;
        m_owner[k] = g;
        m_last[k]  = g;
        m_pend[k]  = ew ? -1 : g;
      end
    end
  end

  task automatic set_in(input logic r0, input logic [15:0] a0, input logic [7:0] d0, input logic w0,
                        input logic r1, input logic [15:0] a1, input logic [7:0] d1, input logic w1);
    req0 = r0; addr0 = a0; wdata0 = d0; we0 = w0;
    req1 = r1; addr1 = a1; wdata1 = d1; we1 = w1;
  endtask

  task automatic idle();
    set_in(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  logic exp0;

  initial begin
    reset = 1'b1;
    bus_rdata = 8'h00;
    set_in(1'b1, 16'h1234, 8'h55, 1'b1, 1'b1, 16'h4321, 8'h66, 1'b1);
    tick(); tick();
    settle();
    for (int k = 0; k < 2; k++) begin
      chk("rst_gnt0",    k, gnt0_o[k],    1'b0);
      chk("rst_gnt1",    k, gnt1_o[k],    1'b0);
      chk("rst_bus_we",  k, bus_we_o[k],  1'b0);
      chk("rst_rvalid0", k, rvalid0_o[k], 1'b0);
    end
    tick();

    // Single read by port 0, data returned next cycle
    reset = 1'b0;
    set_in(1'b1, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    bus_rdata = 8'h11;
    settle();
    chk("rd_gnt0",     0, gnt0_o[0],     1'b1);
    chk("rd_bus_addr", 0, bus_addr_o[0], 16'h0010);
    chk("rd_bus_we",   0, bus_we_o[0],   1'b0);
    chk("rd_rvalid1",  0, rvalid1_o[0],  1'b0);
    tick();
    idle();
    bus_rdata = 8'hA5;
    settle();
    chk("ret_rvalid0", 0, rvalid0_o[0], 1'b1);
    chk("ret_rdata0",  0, rdata0_o[0],  8'hA5);
    chk("ret_rvalid1", 0, rvalid1_o[0], 1'b0);
    tick();

    // Tie after reset, then continuous contention
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 16'h0100 + 16'(i), 8'(i), 1'b0, 1'b1, 16'h0200 + 16'(i), 8'(i), 1'b0);
      bus_rdata = 8'h40 + 8'(i);
      settle();
      exp0 = (i < 4) || (i >= 8);
      chk("cont4_gnt0", 0, gnt0_o[0], exp0);
      chk("cont4_gnt1", 0, gnt1_o[0], !exp0);
      chk("cont1_gnt0", 1, gnt0_o[1], (i % 2) == 0);
      chk("cont1_gnt1", 1, gnt1_o[1], (i % 2) == 1);
      tick();
    end

    // Port 1 write with port 0 idle
    idle();
    tick();
    set_in(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 16'h8400, 8'h3C, 1'b1);
    settle();
    chk("wr_gnt1",      0, gnt1_o[0],      1'b1);
    chk("wr_bus_addr",  0, bus_addr_o[0],  16'h8400);
    chk("wr_bus_wdata", 0, bus_wdata_o[0], 8'h3C);
    chk("wr_bus_we",    0, bus_we_o[0],    1'b1);
    tick();
    idle();
    bus_rdata = 8'hEE;
    settle();
    chk("wr_no_rvalid0", 0, rvalid0_o[0], 1'b0);
    chk("wr_no_rvalid1", 0, rvalid1_o[0], 1'b0);
    tick();

    // Interleaved reads P0, P1, P0
    set_in(1'b1, 16'h0001, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    bus_rdata = 8'h01;
    tick();
    set_in(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, 16'hF800, 8'h0, 1'b0);
    bus_rdata = 8'hC1;
    settle();
    chk("il_rvalid0_a", 1, rvalid0_o[1], 1'b1);
    chk("il_rdata0_a",  1, rdata0_o[1],  8'hC1);
    tick();
    set_in(1'b1, 16'h0002, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    bus_rdata = 8'hC2;
    settle();
    chk("il_rvalid1", 1, rvalid1_o[1], 1'b1);
    chk("il_rdata1",  1, rdata1_o[1],  8'hC2);
    chk("il_rvalid0", 1, rvalid0_o[1], 1'b0);
    tick();
    idle();
    bus_rdata = 8'hC3;
    settle();
    chk("il_rvalid0_b", 1, rvalid0_o[1], 1'b1);
    chk("il_rdata0_b",  1, rdata0_o[1],  8'hC3);
    tick();

    // Reset in the cycle after a granted read squashes the return
    set_in(1'b1, 16'h0033, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    tick();
    reset = 1'b1;
    idle();
    bus_rdata = 8'h77;
    settle();
    for (int k = 0; k < 2; k++) chk("sq_rvalid0", k, rvalid0_o[k], 1'b0);
    tick();
    reset = 1'b0;
    set_in(1'b1, 16'h0044, 8'h0, 1'b0, 1'b1, 16'h0055, 8'h0, 1'b0);
    settle();
    for (int k = 0; k < 2; k++) begin
      chk("sq_tie_gnt0", k, gnt0_o[k],    1'b1);
      chk("sq_rvalid0",  k, rvalid0_o[k], 1'b0);
    end
    tick();

    // Long solo burst by port 0 saturates the counter; contention switches at once
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 16'h1000 + 16'(i), 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
      bus_rdata = 8'h80 + 8'(i);
      tick();
    end
    set_in(1'b1, 16'h2000, 8'h0, 1'b0, 1'b1, 16'h3000, 8'h0, 1'b0);
    settle();
    chk("sat_gnt1", 0, gnt1_o[0], 1'b1);
    tick();

    // Withdrawal mid-burst drops ownership; next tie goes to the port not last granted
    set_in(1'b1, 16'h2100, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    tick(); tick();
    idle();
    tick();
    set_in(1'b1, 16'h2200, 8'h0, 1'b0, 1'b1, 16'h3200, 8'h0, 1'b0);
    settle();
    chk("wd_gnt1", 0, gnt1_o[0], 1'b1);
    tick();

    // Mixed reads and writes under contention and partial requests
    for (int i = 0; i < 16; i++) begin
      set_in(i % 5 != 3, 16'h4000 + 16'(i), 8'h10 + 8'(i), 1'((i >> 1) & 1),
             i % 7 != 2, 16'h5000 + 16'(i), 8'h20 + 8'(i), 1'(i & 1));
      bus_rdata = 8'hB0 + 8'(i);
      tick();
    end
    idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
